freq_divider_prog: RTL and testbench

Runtime-programmable clock-enable divider. It is the parametrised successor of the fixed divide-by-3 counter. It generates a one-cycle tick strobe and a near-50% divided square wave from clk. The divisor is programmable at run time, with the change applied glitch-free at the period boundary. It sits between the system clock and slow peripherals (UART baud, LED scan, sampling strobes) that need clock enables, not new clock domains.

---
 rtl/freq_divider_prog_if.sv | 25 ++
 rtl/freq_divider_prog.sv | 99 +++++++++
 tb/tb_freq_divider_prog.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/freq_divider_prog_if.sv
// Control and status bundle for the programmable clock-enable divider.
// The master side drives run enable and divisor programming; the slave
// side (the divider) returns the phase counter, strobes and divisor status.
interface freq_divider_prog_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] div_val;
    logic             div_load;
    logic [WIDTH-1:0] count;
    logic             tick;
    logic             clk_div;
    logic [WIDTH-1:0] div_cur;
    logic             pending;

    modport master (
        output start, div_val, div_load,
        input  count, tick, clk_div, div_cur, pending
    );

    modport slave (
        input  start, div_val, div_load,
        output count, tick, clk_div, div_cur, pending
    );
endinterface

// File: rtl/freq_divider_prog.sv
// Runtime-programmable clock-enable divider.
// Produces a one-cycle tick once every D cycles and a registered square wave
// that is high for (D+1)>>1 cycles of each period. A new divisor is parked in
// a shadow register and only takes effect at a period boundary, or at once
// while the divider is stopped, so the outputs never show a truncated period.
// A stored divisor of 0 behaves as 1.
//
// Handshake: div_load is a single-cycle strobe with no back-pressure; div_val
// is captured on every rising edge where div_load=1 and ignored otherwise.
module freq_divider_prog #(
    parameter int WIDTH       = 8,
    parameter int DEFAULT_DIV = 3
) (
    input logic                 clk,
    input logic                 rst_n,
    freq_divider_prog_if.slave  bus
);

    localparam logic [WIDTH-1:0] LP_DEFAULT = WIDTH'(DEFAULT_DIV);
    localparam logic [WIDTH-1:0] LP_ONE     = WIDTH'(1);

    logic [WIDTH-1:0] r_count;
    logic             r_tick;
    logic             r_clk_div;
    logic [WIDTH-1:0] r_div_cur;
    logic [WIDTH-1:0] r_shadow;
    logic             r_pending;

    logic [WIDTH-1:0] w_d;
    logic [WIDTH:0]   w_h;
    logic             w_wrap;
    logic [WIDTH-1:0] w_count_next;
    logic             w_clk_div_next;

    // Effective divisor (0 treated as 1) and high length of the square wave.
    // w_h is one bit wider so D+1 cannot overflow at D = 2^WIDTH-1.
    assign w_d    = (r_div_cur == '0) ? LP_ONE : r_div_cur;
    assign w_h    = ({1'b0, w_d} + (WIDTH+1)'(1)) >> 1;
    assign w_wrap = bus.start && (r_count == (w_d - LP_ONE));

    // Next phase value: cleared when stopped or at the end of a period.
    always_comb begin
        w_count_next   = '0;
        if (bus.start && !w_wrap) begin
            w_count_next = r_count + LP_ONE;
        end
        w_clk_div_next = bus.start && ({1'b0, w_count_next} < w_h);
    end

    // Phase counter, output strobes and glitch-free divisor hand-over.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_count   <= '0;
            r_tick    <= 1'b0;
            r_clk_div <= 1'b0;
            r_div_cur <= LP_DEFAULT;
            r_shadow  <= LP_DEFAULT;
            r_pending <= 1'b0;
        end else begin
            r_count   <= w_count_next;
            r_tick    <= w_wrap;
            r_clk_div <= w_clk_div_next;

            if (!bus.start) begin
                // Stopped: no period is running, so a parked divisor is
                // applied straight away; a fresh load waits one edge.
                if (r_pending) begin
                    r_div_cur <= r_shadow;
                    r_pending <= 1'b0;
                end
                if (bus.div_load) begin
                    r_shadow  <= bus.div_val;
                    r_pending <= 1'b1;
                end
            end else if (w_wrap) begin
                // Period boundary: a load on this very edge beats the shadow.
                if (bus.div_load) begin
                    r_div_cur <= bus.div_val;
                    r_shadow  <= bus.div_val;
                    r_pending <= 1'b0;
                end else if (r_pending) begin
                    r_div_cur <= r_shadow;
                    r_pending <= 1'b0;
                end
            end else if (bus.div_load) begin
                // Mid-period: park the request, last write wins.
                r_shadow  <= bus.div_val;
                r_pending <= 1'b1;
            end
        end
    end

    assign bus.count   = r_count;
    assign bus.tick    = r_tick;
    assign bus.clk_div = r_clk_div;
    assign bus.div_cur = r_div_cur;
    assign bus.pending = r_pending;

endmodule

// File: tb/tb_freq_divider_prog.sv
// Bench for freq_divider_prog: a hand-computed vector table on an 8-bit
// instance (default D=3) and a counted run on a 4-bit instance at D=15.
module tb_freq_divider_prog;

    localparam int EW8 = 8 + 1 + 1 + 8 + 1;
    localparam int EW4 = 4 + 1 + 1 + 4 + 1;

    typedef struct {
        logic       rst_n;
        logic       start;
        logic       load;
        logic [7:0] val;
        logic [7:0] cnt;
        logic       tick;
        logic       cdiv;
        logic [7:0] dcur;
        logic       pend;
    } vec_t;

    vec_t             vecs[$];
    logic [EW8-1:0]   exp_q[$];
    logic [EW4-1:0]   exp4_q[$];
    int               n_vec = 0;
    int               n_err = 0;

    // Clock and reset
    logic clk = 1'b0;
    logic rst_n;
    logic rst4_n;
    always #5 clk = ~clk;

    freq_divider_prog_if #(.WIDTH(8)) bus8 ();
    freq_divider_prog_if #(.WIDTH(4)) bus4 ();

    freq_divider_prog #(.WIDTH(8), .DEFAULT_DIV(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus8)
    );

    freq_divider_prog #(.WIDTH(4), .DEFAULT_DIV(15)) dut4 (
        .clk   (clk),
        .rst_n (rst4_n),
        .bus   (bus4)
    );

    // Table entry: inputs for one edge, outputs expected after it.
    task automatic row(input logic r, input logic s, input logic l, input int val,
                       input int cnt, input logic t, input logic c, input int dc,
                       input logic p);
        vec_t v;
        v.rst_n = r;
        v.start = s;
        v.load  = l;
        v.val   = 8'(val);
        v.cnt   = 8'(cnt);
        v.tick  = t;
        v.cdiv  = c;
        v.dcur  = 8'(dc);
        v.pend  = p;
        vecs.push_back(v);
    endtask

    // Scoreboard compare for the 8-bit instance.
    task automatic check8(input int idx);
        logic [EW8-1:0] got;
        logic [EW8-1:0] exp;
        got = {bus8.count, bus8.tick, bus8.clk_div, bus8.div_cur, bus8.pending};
        n_vec++;
        if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL vec%0d scoreboard empty: got %h", idx, got);
        end else begin
            exp = exp_q.pop_front();
            if (got !== exp) begin
                n_err++;
                $display("FAIL vec%0d: got cnt=%0d tick=%0b clk_div=%0b div_cur=%0d pending=%0b, exp cnt=%0d tick=%0b clk_div=%0b div_cur=%0d pending=%0b",
                         idx, got[18:11], got[10], got[9], got[8:1], got[0],
                         exp[18:11], exp[10], exp[9], exp[8:1], exp[0]);
            end
        end
    endtask

    // Scoreboard compare for the 4-bit instance.
    task automatic check4(input int idx);
        logic [EW4-1:0] got;
        logic [EW4-1:0] exp;
        got = {bus4.count, bus4.tick, bus4.clk_div, bus4.div_cur, bus4.pending};
        n_vec++;
        if (exp4_q.size() == 0) begin
            n_err++;
            $display("FAIL w4 cyc%0d scoreboard empty: got %h", idx, got);
        end else begin
            exp = exp4_q.pop_front();
            if (got !== exp) begin
                n_err++;
                $display("FAIL w4 cyc%0d: got cnt=%0d tick=%0b clk_div=%0b div_cur=%0d pending=%0b, exp cnt=%0d tick=%0b clk_div=%0b div_cur=%0d pending=%0b",
                         idx, got[10:7], got[6], got[5], got[4:1], got[0],
                         exp[10:7], exp[6], exp[5], exp[4:1], exp[0]);
            end
        end
    endtask

    initial begin
        rst_n         = 1'b0;
        rst4_n        = 1'b0;
        bus8.start    = 1'b0;
        bus8.div_load = 1'b0;
        bus8.div_val  = '0;
        bus4.start    = 1'b0;
        bus4.div_load = 1'b0;
        bus4.div_val  = '0;

        // Reset, including reset beating a simultaneous start/load
        row(0,0,0,0,   0,0,0,3,0);
        row(0,1,1,9,   0,0,0,3,0);
        // Default D=3, nine cycles
        for (int k = 0; k < 3; k++) begin
            row(1,1,0,0, 1,0,1,3,0);
            row(1,1,0,0, 2,0,0,3,0);
            row(1,1,0,0, 0,1,1,3,0);
        end
        // Load 5 at count=1: parked until the wrap
        row(1,1,0,0,   1,0,1,3,0);
        row(1,1,1,5,   2,0,0,3,1);
        row(1,1,0,0,   0,1,1,5,0);
        row(1,1,0,0,   1,0,1,5,0);
        row(1,1,0,0,   2,0,1,5,0);
        row(1,1,0,0,   3,0,0,5,0);
        row(1,1,0,0,   4,0,0,5,0);
        row(1,1,0,0,   0,1,1,5,0);
        // Load 4 exactly on the wrap edge
        row(1,1,0,0,   1,0,1,5,0);
        row(1,1,0,0,   2,0,1,5,0);
        row(1,1,0,0,   3,0,0,5,0);
        row(1,1,0,0,   4,0,0,5,0);
        row(1,1,1,4,   0,1,1,4,0);
        row(1,1,0,0,   1,0,1,4,0);
        row(1,1,0,0,   2,0,0,4,0);
        row(1,1,0,0,   3,0,0,4,0);
        row(1,1,0,0,   0,1,1,4,0);
        // Back-to-back loads 6 then 7: only 7 applied
        row(1,1,1,6,   1,0,1,4,1);
        row(1,1,1,7,   2,0,0,4,1);
        row(1,1,0,0,   3,0,0,4,1);
        row(1,1,0,0,   0,1,1,7,0);
        row(1,1,0,0,   1,0,1,7,0);
        row(1,1,0,0,   2,0,1,7,0);
        row(1,1,0,0,   3,0,1,7,0);
        row(1,1,0,0,   4,0,0,7,0);
        row(1,1,0,0,   5,0,0,7,0);
        row(1,1,0,0,   6,0,0,7,0);
        row(1,1,0,0,   0,1,1,7,0);
        // D=1 via div_val=0
        row(1,1,1,0,   1,0,1,7,1);
        row(1,1,0,0,   2,0,1,7,1);
        row(1,1,0,0,   3,0,1,7,1);
        row(1,1,0,0,   4,0,0,7,1);
        row(1,1,0,0,   5,0,0,7,1);
        row(1,1,0,0,   6,0,0,7,1);
        row(1,1,0,0,   0,1,1,0,0);
        row(1,1,0,0,   0,1,1,0,0);
        row(1,1,0,0,   0,1,1,0,0);
        row(1,0,0,0,   0,0,0,0,0);
        row(1,0,0,0,   0,0,0,0,0);
        // D=1 via div_val=1, loaded while stopped
        row(1,0,1,1,   0,0,0,0,1);
        row(1,0,0,0,   0,0,0,1,0);
        row(1,1,0,0,   0,1,1,1,0);
        row(1,1,0,0,   0,1,1,1,0);
        row(1,0,0,0,   0,0,0,1,0);
        // D=5, drop start at count=2 for 3 cycles, reassert
        row(1,0,1,5,   0,0,0,1,1);
        row(1,0,0,0,   0,0,0,5,0);
        row(1,1,0,0,   1,0,1,5,0);
        row(1,1,0,0,   2,0,1,5,0);
        row(1,0,0,0,   0,0,0,5,0);
        row(1,0,0,0,   0,0,0,5,0);
        row(1,0,0,0,   0,0,0,5,0);
        row(1,1,0,0,   1,0,1,5,0);
        row(1,1,0,0,   2,0,1,5,0);
        row(1,1,0,0,   3,0,0,5,0);
        row(1,1,0,0,   4,0,0,5,0);
        row(1,1,0,0,   0,1,1,5,0);
        // Reset mid-period with shadow=9 pending
        row(1,1,1,9,   1,0,1,5,1);
        row(1,1,0,0,   2,0,1,5,1);
        row(0,1,0,0,   0,0,0,3,0);
        row(1,1,0,0,   1,0,1,3,0);
        row(1,1,0,0,   2,0,0,3,0);
        row(1,1,0,0,   0,1,1,3,0);
        // Reset during a load, then div_val change without load
        row(0,1,1,9,   0,0,0,3,0);
        row(1,1,0,0,   1,0,1,3,0);
        row(1,1,0,200, 2,0,0,3,0);
        row(1,1,0,200, 0,1,1,3,0);

        // Driver: inputs on the falling edge, outputs checked 1 ns after rise
        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            rst_n         = vecs[i].rst_n;
            bus8.start    = vecs[i].start;
            bus8.div_load = vecs[i].load;
            bus8.div_val  = vecs[i].val;
            exp_q.push_back({vecs[i].cnt, vecs[i].tick, vecs[i].cdiv,
                             vecs[i].dcur, vecs[i].pend});
            @(posedge clk);
            #1;
            check8(i);
        end

        // 4-bit instance at D=15: full period, no overflow
        @(negedge clk);
        rst4_n     = 1'b0;
        bus4.start = 1'b1;
        exp4_q.push_back({4'd0, 1'b0, 1'b0, 4'd15, 1'b0});
        @(posedge clk);
        #1;
        check4(0);
        for (int k = 1; k <= 32; k++) begin
            int ph;
            ph = k % 15;
            @(negedge clk);
            rst4_n = 1'b1;
            exp4_q.push_back({4'(ph), (ph == 0), (ph < 8), 4'd15, 1'b0});
            @(posedge clk);
            #1;
            check4(k);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
